// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2,
      FAULT = 2'd3
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
   localparam int          DEFAULT_MEM_DEPTH = 64;

endpackage

// File: rtl/fetch_unit_imem_array.sv
// Instruction store: one write port, registered read port, storage not reset.
module imem_array #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 64,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [AW-1:0]         waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [AW-1:0]         raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // rdata_q only changes on a read, so it doubles as the hold register on stall.
   always_ff @(posedge clk_i) begin
      if (we_i) mem[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/fetch_unit.sv
// Program-load and instruction-fetch controller in front of a small instruction store.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int MEM_DEPTH  = DEFAULT_MEM_DEPTH,
   localparam int IDXW      = $clog2(MEM_DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  arst_ni,
   input  logic                  load_en_i,
   input  logic                  load_valid_i,
   input  logic [IDXW-1:0]       load_addr_i,
   input  logic [DATA_WIDTH-1:0] load_data_i,
   output logic                  load_ready_o,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] pc_i,
   input  logic                  stall_i,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic                  instr_valid_o,
   output logic                  prog_end_o,
   output logic                  fetch_fault_o,
   output fetch_state_t          state_o
);

   localparam logic [DATA_WIDTH-1:0] NOP     = DATA_WIDTH'(NOP_INSTR);
   localparam logic [ADDR_WIDTH:0]   PC_LIMIT = (ADDR_WIDTH+1)'(4 * MEM_DEPTH);

   fetch_state_t          state_q, state_d;
   logic [IDXW:0]         wc_q, wc_d;
   logic [DATA_WIDTH-1:0] instr_q, instr_d;
   logic                  use_mem_q, use_mem_d;
   logic                  valid_q, valid_d;
   logic                  pend_q, pend_d;
   logic                  fault_q, fault_d;
   logic                  mem_we, mem_re;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic [IDXW-1:0]       idx;
   logic [IDXW:0]         load_top;
   logic                  pc_bad;

   assign idx      = pc_i[IDXW+1:2];
   assign load_top = {1'b0, load_addr_i} + 1'b1;
   assign pc_bad   = (pc_i[1:0] != 2'b00) || ({1'b0, pc_i} >= PC_LIMIT);

   always_comb begin
      state_d   = state_q;
      wc_d      = wc_q;
      instr_d   = instr_q;
      use_mem_d = use_mem_q;
      valid_d   = valid_q;
      pend_d    = pend_q;
      fault_d   = fault_q;
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            pend_d  = 1'b0;
            if (load_en_i) begin
               state_d = LOAD;
               wc_d    = '0;
            end else if (start_i) begin
               state_d = RUN;
            end
         end
         LOAD: begin
            valid_d = 1'b0;
            pend_d  = 1'b0;
            if (load_valid_i) begin
               mem_we = 1'b1;
               if (load_top > wc_q) wc_d = load_top;
            end
            if (!load_en_i) state_d = IDLE;
         end
         RUN: begin
            if (load_en_i) begin
               state_d = LOAD;
               wc_d    = '0;
               valid_d = 1'b0;
               pend_d  = 1'b0;
            end else if (!start_i) begin
               state_d = IDLE;
               valid_d = 1'b0;
               pend_d  = 1'b0;
            end else if (pc_bad) begin
               // Fault outranks stall so a bad pc is never masked by a held output.
               state_d   = FAULT;
               use_mem_d = 1'b0;
               instr_d   = NOP;
               valid_d   = 1'b0;
               pend_d    = 1'b0;
               fault_d   = 1'b1;
            end else if (stall_i) begin
               state_d = RUN;
            end else if ({1'b0, idx} >= wc_q) begin
               use_mem_d = 1'b0;
               instr_d   = NOP;
               valid_d   = 1'b1;
               pend_d    = 1'b1;
            end else begin
               mem_re    = 1'b1;
               use_mem_d = 1'b1;
               valid_d   = 1'b1;
               pend_d    = 1'b0;
            end
         end
         FAULT: begin
            valid_d = 1'b0;
            if (load_en_i) begin
               state_d = LOAD;
               wc_d    = '0;
               fault_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!arst_ni) begin
         state_q   <= IDLE;
         wc_q      <= '0;
         instr_q   <= NOP;
         use_mem_q <= 1'b0;
         valid_q   <= 1'b0;
         pend_q    <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         wc_q      <= wc_d;
         instr_q   <= instr_d;
         use_mem_q <= use_mem_d;
         valid_q   <= valid_d;
         pend_q    <= pend_d;
         fault_q   <= fault_d;
      end
   end

   imem_array #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (MEM_DEPTH)
   ) u_imem (
      .clk_i  (clk_i),
      .we_i   (mem_we && arst_ni),
      .waddr_i(load_addr_i),
      .wdata_i(load_data_i),
      .re_i   (mem_re && arst_ni),
      .raddr_i(idx),
      .rdata_o(mem_rdata)
   );

   assign load_ready_o  = (state_q == LOAD);
   assign instr_o       = use_mem_q ? mem_rdata : instr_q;
   assign instr_valid_o = valid_q;
   assign prog_end_o    = pend_q;
   assign fetch_fault_o = fault_q;
   assign state_o       = state_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32: instruction and load-data width in bits.
REQ-002 Parameter ADDR_WIDTH, default 32: PC width in bits (byte address).
REQ-003 Parameter MEM_DEPTH, default 64: instruction store depth in words; power of two.
REQ-004 The block SHALL use one clock; reset is synchronous and active-low (name the clock and reset ports as the codebase does; the polarity and synchronicity here are fixed).
REQ-005 clk  in  1  rising-edge clock.
REQ-006 arst_n  in  1  reset, active-low, sampled on clk edge.
REQ-007 load_en  in  1  request program-load mode.
REQ-008 load_valid  in  1  load word present this cycle.
REQ-009 load_addr  in  $clog2(MEM_DEPTH)  word index of the load word.
REQ-010 load_data  in  DATA_WIDTH  instruction word to store.
REQ-011 load_ready  out  1  block accepts load words.
REQ-012 start  in  1  level; run fetch while high.
REQ-013 pc  in  ADDR_WIDTH  byte address from the program counter.
REQ-014 stall  in  1  hold the current instruction output.
REQ-015 instr  out  DATA_WIDTH  fetched instruction, drives the core instruction input.
REQ-016 instr_valid  out  1  instr is a real fetch.
REQ-017 prog_end  out  1  pc is beyond the last loaded word.
REQ-018 fetch_fault  out  1  sticky misaligned or out-of-range fetch.

Function
REQ-019 FSM states: IDLE, LOAD, RUN, FAULT.
REQ-020 IDLE: load_en=1 -> LOAD (priority over start); else start=1 -> RUN.
REQ-021 LOAD: load_ready=1; load_valid=1 writes mem[load_addr]<=load_data in the same edge.
REQ-022 The LOAD entry edge SHALL clear word_count to 0; each accepted write sets word_count to max(word_count, load_addr+1), saturating at MEM_DEPTH.
REQ-023 LOAD: load_en=0 -> IDLE.
REQ-024 load_valid outside LOAD SHALL be ignored and load_ready SHALL be 0.
REQ-025 RUN, stall=0: idx=pc[$clog2(MEM_DEPTH)+1:2]; instr<=mem[idx] and instr_valid<=1, one-cycle latency from pc.
REQ-026 RUN, stall=1: instr, instr_valid and prog_end hold; no memory read.
REQ-027 RUN, idx>=word_count, in range: instr<=NOP (0x00000013), instr_valid<=1, prog_end<=1.
REQ-028 RUN, pc[1:0]!=0 or pc>=4*MEM_DEPTH: -> FAULT; instr<=NOP, instr_valid<=0, fetch_fault<=1.
REQ-029 Fault checks SHALL take priority over stall.
REQ-030 RUN, start=0 -> IDLE; instr_valid<=0, prog_end<=0, instr holds.
REQ-031 RUN, load_en=1 -> LOAD; instr_valid<=0.
REQ-032 FAULT: fetch_fault stays 1 and instr_valid stays 0; only load_en=1 exits, to LOAD, clearing fetch_fault.
REQ-033 In IDLE and LOAD, instr_valid SHALL be 0.

Reset
REQ-034 arst_n=0 at a clk edge: state=IDLE, word_count=0, instr=NOP, instr_valid=0, prog_end=0, fetch_fault=0, load_ready=0.
REQ-035 Reset mid-LOAD or mid-RUN: the above applies; memory contents are not cleared; no write occurs on the reset edge.

Structure
REQ-036 Shared package fetch_pkg holds fetch_state_t (IDLE, LOAD, RUN, FAULT), the NOP_INSTR constant, and the default MEM_DEPTH.
REQ-037 Sub-module imem_array: single write port, synchronous read port, no reset on the storage array.
REQ-038 FSM, word_count and output registers live in fetch_unit.

Verification
REQ-039 Load words 0..3 = 0x00500093, 0x00100113, 0x002081B3, 0x00000013, then start, pc=0,4,8 -> instr equals each word one cycle later; instr_valid=1.
REQ-040 RUN with pc=4, stall=1 for 3 cycles while pc changes to 8 -> instr stays 0x00100113.
REQ-041 With 4 words loaded, pc=16 -> instr=0x00000013, prog_end=1, instr_valid=1, fetch_fault=0.
REQ-042 pc=6 -> FAULT, fetch_fault=1, instr_valid=0; start toggled, fault held; load_en=1 -> fault cleared, load_ready=1.
REQ-043 pc=256 (MEM_DEPTH=64) -> fetch_fault=1.
REQ-044 arst_n=0 for one cycle mid-LOAD after 2 writes -> all outputs at reset values; reload plus start fetches the correct words; load_en=1 and start=1 together from IDLE -> LOAD.
